// File: rtl/ram_arb_pkg.sv
// Shared constants for the two-port data RAM arbiter: FSM states, port indices
// and default RAM geometry.
package ram_arb_pkg;

    localparam int ADDR_W_DEF = 6;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick; the priority pointer itself is kept
// by the caller.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic prio,
    output logic gnt_valid,
    output logic gnt_idx
);

    // pick the requesting port, breaking a tie with the pointer
    always_comb begin
        gnt_valid = req0 | req1;
        if (req0 && req1) begin
            gnt_idx = prio;
        end else if (req1) begin
            gnt_idx = PORT1;
        end else begin
            gnt_idx = PORT0;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester front end for the single-port 64x32 data RAM: request/ack
// handshake, round-robin arbitration, registered RAM drive and read data.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] ram_a,
    output logic [DATA_W-1:0] ram_d,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_spo,
    output logic              busy
);

    state_t              state_r, state_s;
    logic                prio_r, prio_s;
    logic                gnt_r, gnt_s;
    logic [ADDR_W-1:0]   ram_a_r, ram_a_s;
    logic [DATA_W-1:0]   ram_d_r, ram_d_s;
    logic                ram_we_r, ram_we_s;
    logic                p0_ack_r, p0_ack_s;
    logic                p1_ack_r, p1_ack_s;
    logic [DATA_W-1:0]   p0_rdata_r, p0_rdata_s;
    logic [DATA_W-1:0]   p1_rdata_r, p1_rdata_s;
    logic                busy_r, busy_s;
    logic                gnt_valid_s;
    logic                gnt_idx_s;

    rr_arb2 u_rr_arb2 (
        .req0      (p0_req),
        .req1      (p1_req),
        .prio      (prio_r),
        .gnt_valid (gnt_valid_s),
        .gnt_idx   (gnt_idx_s)
    );

    // next-state and next-register values for the access FSM
    always_comb begin
        state_s    = state_r;
        prio_s     = prio_r;
        gnt_s      = gnt_r;
        ram_a_s    = ram_a_r;
        ram_d_s    = ram_d_r;
        ram_we_s   = ram_we_r;
        p0_ack_s   = 1'b0;
        p1_ack_s   = 1'b0;
        p0_rdata_s = p0_rdata_r;
        p1_rdata_s = p1_rdata_r;
        case (state_r)
            IDLE: begin
                if (gnt_valid_s) begin
                    ram_a_s  = (gnt_idx_s == PORT1) ? p1_addr  : p0_addr;
                    ram_d_s  = (gnt_idx_s == PORT1) ? p1_wdata : p0_wdata;
                    ram_we_s = (gnt_idx_s == PORT1) ? p1_we    : p0_we;
                    gnt_s    = gnt_idx_s;
                    prio_s   = ~gnt_idx_s;
                    state_s  = ACCESS;
                end else begin
                    state_s  = IDLE;
                end
            end
            ACCESS: begin
                // ram_spo reflects the registered address here; a write commits at this edge
                if (!ram_we_r && (gnt_r == PORT1)) begin
                    p1_rdata_s = ram_spo;
                end else if (!ram_we_r) begin
                    p0_rdata_s = ram_spo;
                end else begin
                    p0_rdata_s = p0_rdata_r;
                end
                if (gnt_r == PORT1) begin
                    p1_ack_s = 1'b1;
                end else begin
                    p0_ack_s = 1'b1;
                end
                ram_we_s = 1'b0;
                state_s  = ACK;
            end
            ACK: begin
                state_s = IDLE;
            end
            default: begin
                ram_we_s = 1'b0;
                state_s  = IDLE;
            end
        endcase
        busy_s = (state_s != IDLE);
    end

    // state and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            prio_r     <= PORT0;
            gnt_r      <= PORT0;
            ram_a_r    <= {ADDR_W{1'b0}};
            ram_d_r    <= {DATA_W{1'b0}};
            ram_we_r   <= 1'b0;
            p0_ack_r   <= 1'b0;
            p1_ack_r   <= 1'b0;
            p0_rdata_r <= {DATA_W{1'b0}};
            p1_rdata_r <= {DATA_W{1'b0}};
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            prio_r     <= prio_s;
            gnt_r      <= gnt_s;
            ram_a_r    <= ram_a_s;
            ram_d_r    <= ram_d_s;
            ram_we_r   <= ram_we_s;
            p0_ack_r   <= p0_ack_s;
            p1_ack_r   <= p1_ack_s;
            p0_rdata_r <= p0_rdata_s;
            p1_rdata_r <= p1_rdata_s;
            busy_r     <= busy_s;
        end
    end

    assign ram_a    = ram_a_r;
    assign ram_d    = ram_d_r;
    assign ram_we   = ram_we_r;
    assign p0_ack   = p0_ack_r;
    assign p1_ack   = p1_ack_r;
    assign p0_rdata = p0_rdata_r;
    assign p1_rdata = p1_rdata_r;
    assign busy     = busy_r;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: behavioural RAM plus a transaction-level
// memory/priority model, randomized accesses and directed corner cases.
module tb_ram_arbiter;

    localparam int AW = 6;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
    logic [AW-1:0] p0_addr = '0, p1_addr = '0;
    logic [DW-1:0] p0_wdata = '0, p1_wdata = '0;
    logic          p0_ack, p1_ack, ram_we, busy;
    logic [DW-1:0] p0_rdata, p1_rdata, ram_d, ram_spo;
    logic [AW-1:0] ram_a;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc = 0, we_cnt = 0, ack_total = 0;
    logic [AW-1:0] last_we_a = '0;
    logic [DW-1:0] last_we_d = '0;
    logic [DW-1:0] ram_mem [64] = '{default: '0};
    logic [DW-1:0] ref_mem [64] = '{default: '0};
    bit model_prio = 1'b0;

    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .ram_a(ram_a), .ram_d(ram_d), .ram_we(ram_we), .ram_spo(ram_spo), .busy(busy)
    );

    always #5 clk = ~clk;

    // behavioural single-port RAM with asynchronous read
    assign ram_spo = ram_mem[ram_a];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_we) ram_mem[ram_a] <= ram_d;
    end

    // observe write strobes and acks between edges
    always @(negedge clk) begin
        if (ram_we) begin
            we_cnt    <= we_cnt + 1;
            last_we_a <= ram_a;
            last_we_d <= ram_d;
        end
        if (p0_ack || p1_ack) ack_total <= ack_total + 1;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 500000");
        $fatal(1);
    end

    // one access on one port; returns what was observed, no judgement
    task automatic run_access(input bit port, input bit we, input logic [AW-1:0] addr,
                              input logic [DW-1:0] wd, output int lat, output logic [DW-1:0] rd,
                              output int we_delta, output int busy_cnt, output logic ack_after);
        int c0, w0;
        @(negedge clk);
        if (port) begin p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wd; end
        else      begin p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wd; end
        c0 = cyc; w0 = we_cnt; lat = -1; rd = 'x; busy_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if ((port ? p1_ack : p0_ack) === 1'b1) begin
                lat = cyc - c0;
                rd  = port ? p1_rdata : p0_rdata;
                break;
            end
        end
        p0_req = 1'b0; p1_req = 1'b0;
        we_delta = we_cnt - w0;
        @(negedge clk);
        ack_after = port ? p1_ack : p0_ack;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({p0_ack, p1_ack, busy, ram_we, ram_a, ram_d, p0_rdata, p1_rdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ack=%b%b busy=%b we=%b a=%0d d=%h rd0=%h rd1=%h, required all zero",
                     p0_ack, p1_ack, busy, ram_we, ram_a, ram_d, p0_rdata, p1_rdata);
        end
        rst_n = 1'b1;
        model_prio = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_single_read;
        int lat, wd, bc; logic [DW-1:0] rd; logic aa;
        run_access(1'b0, 1'b0, 6'd0, 32'h0, lat, rd, wd, bc, aa);
        model_prio = 1'b1;
        n_checks++;
        if (lat !== 2 || rd !== 32'h0 || wd !== 0 || bc !== 2 || aa !== 1'b0 || ram_a !== 6'd0) begin
            n_fail++;
            $display("FAIL single_read: lat=%0d rd=%h we_cycles=%0d busy_cycles=%0d ack_after=%b a=%0d, required 2/0/0/2/0/0",
                     lat, rd, wd, bc, aa, ram_a);
        end
    endtask

    task automatic test_write_read;
        int lat, wd, bc; logic [DW-1:0] rd; logic aa;
        run_access(1'b1, 1'b1, 6'd1, 32'd23, lat, rd, wd, bc, aa);
        ref_mem[1] = 32'd23; model_prio = 1'b0;
        n_checks++;
        if (lat !== 2 || wd !== 1 || last_we_a !== 6'd1 || last_we_d !== 32'd23 || aa !== 1'b0) begin
            n_fail++;
            $display("FAIL write_p1: lat=%0d we_cycles=%0d a=%0d d=%0d ack_after=%b, required 2/1/1/23/0",
                     lat, wd, last_we_a, last_we_d, aa);
        end
        run_access(1'b1, 1'b0, 6'd1, 32'h0, lat, rd, wd, bc, aa);
        model_prio = 1'b0;
        n_checks++;
        if (lat !== 2 || rd !== ref_mem[1] || wd !== 0 || aa !== 1'b0) begin
            n_fail++;
            $display("FAIL read_p1: lat=%0d rd=%0d we_cycles=%0d ack_after=%b, required 2/%0d/0/0",
                     lat, rd, wd, aa, ref_mem[1]);
        end
    endtask

    task automatic test_contention;
        bit exp_w; int first; int ack_c [2]; bit seen [2]; int c0;
        logic [DW-1:0] rd0, exp_rd0;
        int lat, wd, bc; logic [DW-1:0] rd; logic aa;
        exp_w = model_prio;
        exp_rd0 = (exp_w == 1'b0) ? ref_mem[5] : 32'hDEADBEEF;
        @(negedge clk);
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 6'd5; p0_wdata = 32'h0;
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 6'd5; p1_wdata = 32'hDEADBEEF;
        c0 = cyc; first = -1; seen = '{1'b0, 1'b0}; ack_c = '{-1, -1}; rd0 = 'x;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (p0_ack && !seen[0]) begin
                seen[0] = 1'b1; ack_c[0] = cyc - c0; rd0 = p0_rdata; p0_req = 1'b0;
                if (first < 0) first = 0;
            end
            if (p1_ack && !seen[1]) begin
                seen[1] = 1'b1; ack_c[1] = cyc - c0; p1_req = 1'b0;
                if (first < 0) first = 1;
            end
            if (seen[0] && seen[1]) break;
        end
        p0_req = 1'b0; p1_req = 1'b0;
        ref_mem[5] = 32'hDEADBEEF;
        n_checks++;
        if (first !== int'(exp_w) || ack_c[exp_w] !== 2 || ack_c[~exp_w] !== 5) begin
            n_fail++;
            $display("FAIL contention_order: first=%0d ack_at=%0d/%0d, required first=%0d winner@2 loser@5",
                     first, ack_c[0], ack_c[1], exp_w);
        end
        n_checks++;
        if (rd0 !== exp_rd0) begin
            n_fail++;
            $display("FAIL contention_p0_data: got %h, required %h", rd0, exp_rd0);
        end
        run_access(1'b0, 1'b0, 6'd5, 32'h0, lat, rd, wd, bc, aa);
        model_prio = 1'b1;
        n_checks++;
        if (lat !== 2 || rd !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL contention_reread: lat=%0d rd=%h, required 2/deadbeef", lat, rd);
        end
    endtask

    task automatic test_random;
        int lat, wd, bc; logic [DW-1:0] rd, data; logic aa;
        bit port, we; logic [AW-1:0] addr; int unsigned r;
        for (int i = 0; i < 24; i++) begin
            r = $urandom;
            port = r[8]; we = r[9]; addr = {3'b000, r[2:0]};
            data = $urandom;
            if (i < 2) begin addr = 6'd63; we = (i == 0); end
            run_access(port, we, addr, data, lat, rd, wd, bc, aa);
            model_prio = ~port;
            n_checks++;
            if (lat !== 2 || wd !== int'(we) || aa !== 1'b0 || (!we && rd !== ref_mem[addr]) ||
                (we && (last_we_a !== addr || last_we_d !== data))) begin
                n_fail++;
                $display("FAIL random_%0d: port=%0d we=%0d addr=%0d lat=%0d we_cycles=%0d rd=%h ack_after=%b, required lat=2 rd=%h",
                         i, port, we, addr, lat, wd, rd, aa, ref_mem[addr]);
            end
            if (we) ref_mem[addr] = data;
        end
    endtask

    task automatic test_fairness;
        int n_ack; int log_port [4]; int log_cyc [4]; int remaining [2];
        logic [AW-1:0] a0, a1; logic [DW-1:0] rd_bad; int bad_rd; int c0; bit exp;
        int unsigned r;
        exp = model_prio;
        r = $urandom; a0 = {3'b000, r[2:0]}; a1 = {3'b000, r[5:3]};
        @(negedge clk);
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = a0;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = a1;
        c0 = cyc; n_ack = 0; remaining = '{2, 2}; bad_rd = 0; rd_bad = '0;
        for (int i = 0; i < 20 && n_ack < 4; i++) begin
            @(negedge clk);
            if (p0_ack && n_ack < 4) begin
                log_port[n_ack] = 0; log_cyc[n_ack] = cyc - c0; n_ack++;
                if (p0_rdata !== ref_mem[a0]) begin bad_rd++; rd_bad = p0_rdata; end
                remaining[0]--;
                r = $urandom; a0 = {3'b000, r[2:0]}; p0_addr = a0;
                if (remaining[0] == 0) p0_req = 1'b0;
            end
            if (p1_ack && n_ack < 4) begin
                log_port[n_ack] = 1; log_cyc[n_ack] = cyc - c0; n_ack++;
                if (p1_rdata !== ref_mem[a1]) begin bad_rd++; rd_bad = p1_rdata; end
                remaining[1]--;
                r = $urandom; a1 = {3'b000, r[2:0]}; p1_addr = a1;
                if (remaining[1] == 0) p1_req = 1'b0;
            end
        end
        p0_req = 1'b0; p1_req = 1'b0;
        n_checks++;
        if (n_ack !== 4) begin
            n_fail++;
            $display("FAIL fairness_count: got %0d acks, required 4", n_ack);
        end
        for (int k = 0; k < 4 && k < n_ack; k++) begin
            n_checks++;
            if (log_port[k] !== int'(exp ^ k[0]) || log_cyc[k] !== 2 + 3 * k) begin
                n_fail++;
                $display("FAIL fairness_ack%0d: port=%0d at +%0d, required port=%0d at +%0d",
                         k, log_port[k], log_cyc[k], exp ^ k[0], 2 + 3 * k);
            end
        end
        n_checks++;
        if (bad_rd !== 0) begin
            n_fail++;
            $display("FAIL fairness_rdata: %0d wrong reads (last %h), required 0", bad_rd, rd_bad);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_in_access;
        int lat, wd, bc, snap; logic [DW-1:0] rd; logic aa;
        run_access(1'b0, 1'b1, 6'd2, 32'h1234_5678, lat, rd, wd, bc, aa);
        ref_mem[2] = 32'h1234_5678;
        @(negedge clk);
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 6'd2; p0_wdata = 32'd7;
        @(negedge clk);
        n_checks++;
        if ({ram_we, ram_a, ram_d} !== {1'b1, 6'd2, 32'd7}) begin
            n_fail++;
            $display("FAIL rst_access_setup: we=%b a=%0d d=%0d, required 1/2/7", ram_we, ram_a, ram_d);
        end
        snap = ack_total;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (ram_we !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_async: we=%b busy=%b, required 0/0", ram_we, busy);
        end
        p0_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_prio = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (ack_total !== snap || p0_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_no_ack: acks=%0d rd0=%h, required %0d/0", ack_total, p0_rdata, snap);
        end
        run_access(1'b1, 1'b0, 6'd2, 32'h0, lat, rd, wd, bc, aa);
        model_prio = 1'b0;
        n_checks++;
        if (lat !== 2 || rd !== ref_mem[2]) begin
            n_fail++;
            $display("FAIL rst_reread: lat=%0d rd=%h, required 2/%h", lat, rd, ref_mem[2]);
        end
    endtask

    task automatic test_idle_hold;
        int bad;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || ram_we !== 1'b0 || p0_ack !== 1'b0 || p1_ack !== 1'b0) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL idle_hold: %0d active cycles, required 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write_read();
        test_contention();
        test_random();
        test_fairness();
        test_reset_in_access();
        test_idle_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
